// File: rtl/terminal_write_arbiter.sv
// Round-robin arbiter for the terminal text-RAM write port (debugger overlay vs CPU console),
// with a built-in sequencer that fills the whole screen with CLEAR_CHAR.
module terminal_write_arbiter #(
  parameter int                    ADDR_WIDTH = 12,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    TEXT_DEPTH = 2400,
  parameter logic [DATA_WIDTH-1:0] CLEAR_CHAR = 8'h20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  dbg_ack,
  input  logic                  con_req,
  input  logic [ADDR_WIDTH-1:0] con_addr,
  input  logic [DATA_WIDTH-1:0] con_data,
  output logic                  con_ack,
  input  logic                  clear_req,
  output logic                  clear_busy,
  output logic [ADDR_WIDTH-1:0] terminal_addr,
  output logic                  terminal_write,
  output logic [DATA_WIDTH-1:0] terminal_data
);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
  // rr pointer names the requester that wins the next tie.
  typedef enum logic {PICK_DBG, PICK_CON} pick_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(TEXT_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

  state_e                state_q, state_d;
  pick_e                 rr_q, rr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  write_q, write_d;
  logic                  dbg_ack_q, dbg_ack_d;
  logic                  con_ack_q, con_ack_d;
  logic                  busy_q, busy_d;

  logic dbg_elig, con_elig, grant_dbg, grant_con;

  // A requester whose ack is on the wire this cycle has not yet seen it, so its req is stale.
  assign dbg_elig  = dbg_req & ~dbg_ack_q;
  assign con_elig  = con_req & ~con_ack_q;
  assign grant_dbg = dbg_elig & (~con_elig | (rr_q == PICK_DBG));
  assign grant_con = con_elig & ~grant_dbg;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    state_d   = state_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    write_d   = 1'b0;
    dbg_ack_d = 1'b0;
    con_ack_d = 1'b0;
    busy_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          // First clear write is registered on the same edge that accepts the request.
          write_d = 1'b1;
          addr_d  = '0;
          data_d  = CLEAR_CHAR;
          busy_d  = 1'b1;
          cnt_d   = ADDR_ONE;
          state_d = (TEXT_DEPTH == 1) ? ST_IDLE : ST_CLEAR;
        end else if (grant_dbg) begin
          write_d   = 1'b1;
          addr_d    = dbg_addr;
          data_d    = dbg_data;
          dbg_ack_d = 1'b1;
          rr_d      = PICK_CON;
        end else if (grant_con) begin
          write_d   = 1'b1;
          addr_d    = con_addr;
          data_d    = con_data;
          con_ack_d = 1'b1;
          rr_d      = PICK_DBG;
        end
      end
      ST_CLEAR: begin
        write_d = 1'b1;
        addr_d  = cnt_q;
        data_d  = CLEAR_CHAR;
        busy_d  = 1'b1;
        cnt_d   = cnt_q + ADDR_ONE;
        if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_q      <= PICK_DBG;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      dbg_ack_q <= 1'b0;
      con_ack_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      write_q   <= write_d;
      dbg_ack_q <= dbg_ack_d;
      con_ack_q <= con_ack_d;
      busy_q    <= busy_d;
    end
  end

  assign terminal_write = write_q;
  assign terminal_addr  = addr_q;
  assign terminal_data  = data_q;
  assign dbg_ack        = dbg_ack_q;
  assign con_ack        = con_ack_q;
  assign clear_busy     = busy_q;

endmodule

// File: tb/tb_terminal_write_arbiter.sv
// Randomized bench for terminal_write_arbiter: a behavioural model predicts every output cycle,
// plus directed handshake, alternation, clear and reset scenarios.
module tb_terminal_write_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 8;
  localparam int DEPTH = 2400;

  logic          clock = 1'b0;
  logic          reset;
  logic          dbg_req, con_req, clear_req;
  logic [AW-1:0] dbg_addr, con_addr;
  logic [DW-1:0] dbg_data, con_data;
  logic          dbg_ack, con_ack, clear_busy, terminal_write;
  logic [AW-1:0] terminal_addr;
  logic [DW-1:0] terminal_data;

  int tests_run    = 0;
  int tests_failed = 0;

  terminal_write_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TEXT_DEPTH(DEPTH), .CLEAR_CHAR(8'h20)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .dbg_req       (dbg_req),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data),
    .dbg_ack       (dbg_ack),
    .con_req       (con_req),
    .con_addr      (con_addr),
    .con_data      (con_data),
    .con_ack       (con_ack),
    .clear_req     (clear_req),
    .clear_busy    (clear_busy),
    .terminal_addr (terminal_addr),
    .terminal_write(terminal_write),
    .terminal_data (terminal_data)
  );

  always #5 clock = ~clock;

  // Reference model: what the write port shows during the coming cycle.
  logic          m_write, m_dack, m_cack, m_busy;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  int            clear_left, clear_next;
  bit            con_won_last;  // set at reset so the debugger wins the first tie

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] dut_vec();
    return {8'h00, terminal_write, terminal_addr, terminal_data, dbg_ack, con_ack, clear_busy};
  endfunction

  function automatic logic [31:0] exp_vec();
    return {8'h00, m_write, m_addr, m_data, m_dack, m_cack, m_busy};
  endfunction

  task automatic model_reset();
    m_write = 0; m_dack = 0; m_cack = 0; m_busy = 0; m_addr = '0; m_data = '0;
    clear_left = 0; clear_next = 0; con_won_last = 1;
  endtask

  // Applies the arbitration rules to the inputs the next edge will sample.
  task automatic model_edge();
    bit d_ok, c_ok;
    d_ok = dbg_req && !m_dack;
    c_ok = con_req && !m_cack;
    m_dack = 0; m_cack = 0;
    if (clear_left > 0) begin
      m_write = 1; m_addr = AW'(clear_next); m_data = 8'h20; m_busy = 1;
      clear_next++; clear_left--;
    end else if (clear_req) begin
      m_write = 1; m_addr = '0; m_data = 8'h20; m_busy = 1;
      clear_next = 1; clear_left = DEPTH - 1;
    end else begin
      m_busy = 0;
      if (d_ok && (!c_ok || con_won_last)) begin
        m_write = 1; m_addr = dbg_addr; m_data = dbg_data; m_dack = 1; con_won_last = 0;
      end else if (c_ok) begin
        m_write = 1; m_addr = con_addr; m_data = con_data; m_cack = 1; con_won_last = 1;
      end else begin
        m_write = 0;
      end
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clock);
    #1;
    check_eq(tag, dut_vec(), exp_vec());
  endtask

  task automatic async_reset_check(input string tag);
    #2 reset = 1'b1;
    #1 check_eq({tag, "_async"}, dut_vec(), 32'h0);
    @(posedge clock);
    #1 check_eq({tag, "_held"}, dut_vec(), 32'h0);
    reset = 1'b0;
    model_reset();
  endtask

  int issued, served, ok_cnt, clears, budget;
  bit con_ack_in_clear;

  initial begin
    reset = 1'b1;
    dbg_req = 0; con_req = 0; clear_req = 0;
    dbg_addr = '0; dbg_data = '0; con_addr = '0; con_data = '0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 check_eq("rst_init", dut_vec(), 32'h0);
    reset = 1'b0;

    // Both requesters busy from reset: strict dbg/con alternation, one write per cycle.
    dbg_req = 1; dbg_addr = 12'h010; dbg_data = 8'h61;
    con_req = 1; con_addr = 12'h020; con_data = 8'h71;
    for (int i = 0; i < 8; i++) begin
      step("both_req");
      check_eq("alternate", {30'd0, dbg_ack, con_ack}, (i % 2 == 0) ? 32'd2 : 32'd1);
      if (dbg_ack) begin dbg_addr = AW'($urandom); dbg_data = DW'($urandom); end
      if (con_ack) begin con_addr = AW'($urandom); con_data = DW'($urandom); end
    end

    // Reset in the middle of that traffic.
    async_reset_check("rst_traffic");
    dbg_req = 0; con_req = 0;
    step("idle_after_rst");

    // Single debugger write, then a second request held with new data.
    dbg_req = 1; dbg_addr = 12'h005; dbg_data = 8'h41;
    step("dbg_w1");
    check_eq("dbg_w1_addr", 32'(terminal_addr), 32'h005);
    check_eq("dbg_w1_data", 32'(terminal_data), 32'h41);
    check_eq("dbg_w1_ack", 32'(dbg_ack), 32'h1);
    dbg_addr = 12'h006; dbg_data = 8'h42;
    step("dbg_gap");
    check_eq("dbg_gap_write", 32'(terminal_write), 32'h0);
    step("dbg_w2");
    check_eq("dbg_w2_vals", {11'd0, terminal_write, terminal_addr, terminal_data, dbg_ack},
             {11'd0, 1'b1, 12'h006, 8'h42, 1'b1});
    dbg_req = 0;
    step("dbg_drop");

    // Full clear; console request arrives mid-clear and a stray clear_req is ignored.
    clear_req = 1;
    ok_cnt = 0; con_ack_in_clear = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step("clear");
      clear_req = 0;
      if (terminal_write && clear_busy && terminal_addr == AW'(i) && terminal_data == 8'h20)
        ok_cnt++;
      if (con_ack) con_ack_in_clear = 1;
      if (i == 100) begin con_req = 1; con_addr = 12'h7FF; con_data = 8'h55; end
      if (i == 500) clear_req = 1;
    end
    check_eq("clear_writes", ok_cnt, DEPTH);
    check_eq("clear_no_ack", 32'(con_ack_in_clear), 32'h0);
    step("con_after_clear");
    check_eq("con_after_clear_vals",
             {10'd0, terminal_write, terminal_addr, terminal_data, con_ack, clear_busy},
             {10'd0, 1'b1, 12'h7FF, 8'h55, 1'b1, 1'b0});
    con_req = 0;
    step("con_drop");

    // Reset at clear write 1000: sequence is abandoned, not resumed.
    clear_req = 1;
    step("clr2_start");
    clear_req = 0;
    for (int i = 1; i <= 1000; i++) step("clr2");
    check_eq("clr2_addr1000", 32'(terminal_addr), 32'd1000);
    async_reset_check("rst_clear");
    for (int i = 0; i < 5; i++) step("no_resume");

    // Randomized traffic against the model, with occasional clears.
    issued = 0; served = 0; clears = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (dbg_req && dbg_ack) begin
        served++;
        if ($urandom_range(3) != 0) begin
          dbg_addr = AW'($urandom); dbg_data = DW'($urandom); issued++;
        end else dbg_req = 0;
      end else if (!dbg_req && $urandom_range(2) == 0) begin
        dbg_req = 1; dbg_addr = AW'($urandom); dbg_data = DW'($urandom); issued++;
      end
      if (con_req && con_ack) begin
        served++;
        if ($urandom_range(3) != 0) begin
          con_addr = AW'($urandom); con_data = DW'($urandom); issued++;
        end else con_req = 0;
      end else if (!con_req && $urandom_range(2) == 0) begin
        con_req = 1; con_addr = AW'($urandom); con_data = DW'($urandom); issued++;
      end
      clear_req = 0;
      if (clear_busy && $urandom_range(999) == 0) clear_req = 1;
      else if (!clear_busy && clears < 2 && $urandom_range(399) == 0) begin
        clear_req = 1; clears++;
      end
      step("random");
    end

    // Drain: every issued request must be acknowledged exactly once.
    clear_req = 0;
    budget = 0;
    while ((dbg_req || con_req) && budget < 3000) begin
      if (dbg_req && dbg_ack) begin served++; dbg_req = 0; end
      if (con_req && con_ack) begin served++; con_req = 0; end
      if (dbg_req || con_req) step("drain");
      budget++;
    end
    check_eq("drain_done", 32'(dbg_req || con_req), 32'h0);
    check_eq("served_all", served, issued);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
